riscv_multi_mainfsm: RTL and testbench

Wait-state-aware main control FSM for the multi-cycle RV32I core, successor to the fixed-latency controller FSM. It sequences FETCH/DECODE/EXECUTE/WRITEBACK and drives all datapath mux selects and write strobes. Memory accesses use a req/ready handshake with parametrised timeout. The block adds a debug-halt state and a sticky fault state for illegal opcodes and bus timeouts. It sits inside `controller`, beside the ALU decoder, between the instruction register fields and the datapath enables.

---
 rtl/riscv_multi_pkg.sv | 65 ++++++
 rtl/riscv_multi_mainfsm_if.sv | 9 +
 rtl/mainfsm_waitcnt.sv | 32 +++
 rtl/riscv_multi_mainfsm.sv | 168 ++++++++++++++++
 tb/tb_riscv_multi_mainfsm.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_multi_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// datapath mux-select codes and the packed control word the main FSM produces.
package riscv_multi_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEMADR   = 4'd2;
   localparam state_t S_MEMREAD  = 4'd3;
   localparam state_t S_MEMWB    = 4'd4;
   localparam state_t S_MEMWRITE = 4'd5;
   localparam state_t S_EXECR    = 4'd6;
   localparam state_t S_EXECI    = 4'd7;
   localparam state_t S_ALUWB    = 4'd8;
   localparam state_t S_BEQ      = 4'd9;
   localparam state_t S_JAL      = 4'd10;
   localparam state_t S_HALT     = 4'd11;
   localparam state_t S_FAULT    = 4'd12;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] alu_op;
      logic [1:0] imm_src;
      logic       halted;
      logic       fault;
   } ctrl_t;

endpackage

// File: rtl/riscv_multi_mainfsm_if.sv
// Memory request/ready handshake between the main FSM (master) and memory (slave).
interface riscv_multi_mainfsm_if;
   logic mem_req;
   logic MemWrite;
   logic mem_ready;

   modport master (output mem_req, output MemWrite, input mem_ready);
   modport slave  (input mem_req, input MemWrite, output mem_ready);
endinterface

// File: rtl/mainfsm_waitcnt.sv
// Per-access wait counter with timeout compare.
// Latency: timeout is combinational on the current count and ready.
// Backpressure: counts cycles of req without ready; ready at the limit still completes.
module mainfsm_waitcnt #(
   parameter int WAIT_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic ready,
   output logic timeout
);

   localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

   logic [WAIT_W-1:0] cnt;

   // Any cycle that is not a stalled request restarts the count, so every
   // request state is entered with a cleared counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (req && !ready)
         cnt <= cnt + WAIT_W'(1);
      else
         cnt <= '0;
   end

   assign timeout = req && !ready && (cnt == LIMIT);

endmodule

// File: rtl/riscv_multi_mainfsm.sv
// Main control FSM of the multi-cycle RV32I core with wait states, debug halt and sticky fault.
// Latency: zero-wait load 5, store/R/I/jal 4, beq 3 cycles; each memory wait adds 1.
// Backpressure: mem_req held until mem_ready; TIMEOUT stalled cycles send the FSM to FAULT.
module riscv_multi_mainfsm
   import riscv_multi_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int WAIT_W  = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   riscv_multi_mainfsm_if.master        mem,
   input  logic [6:0]                   op,
   input  logic                         Zero,
   input  logic                         halt_req,
   output logic                         AdrSrc,
   output logic                         IRWrite,
   output logic                         PCWrite,
   output logic                         RegWrite,
   output logic [1:0]                   ALUSrcA,
   output logic [1:0]                   ALUSrcB,
   output logic [1:0]                   ResultSrc,
   output logic [1:0]                   ALUOp,
   output logic [1:0]                   ImmSrc,
   output logic                         halted,
   output logic                         fault
);

   state_t state, state_nxt, fetch_or_halt;
   ctrl_t  c, ctrl;
   logic   req_raw, timeout;

   assign req_raw = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);

   mainfsm_waitcnt #(.WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) u_waitcnt (
      .clk     (clk),
      .reset   (reset),
      .req     (req_raw),
      .ready   (mem.mem_ready),
      .timeout (timeout)
   );

   // A halt request is honoured only where a new fetch would begin, so an
   // issued memory request is always carried through to completion.
   assign fetch_or_halt = halt_req ? S_HALT : S_FETCH;

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:    if (mem.mem_ready) state_nxt = S_DECODE;
                     else if (timeout)  state_nxt = S_FAULT;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_RTYPE:          state_nxt = S_EXECR;
               OP_ITYPE:          state_nxt = S_EXECI;
               OP_BRANCH:         state_nxt = S_BEQ;
               OP_JAL:            state_nxt = S_JAL;
               default:           state_nxt = S_FAULT;
            endcase
         end
         S_MEMADR:   state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem.mem_ready) state_nxt = S_MEMWB;
                     else if (timeout)  state_nxt = S_FAULT;
         S_MEMWB:    state_nxt = fetch_or_halt;
         S_MEMWRITE: if (mem.mem_ready) state_nxt = fetch_or_halt;
                     else if (timeout)  state_nxt = S_FAULT;
         S_EXECR,
         S_EXECI:    state_nxt = S_ALUWB;
         S_ALUWB:    state_nxt = fetch_or_halt;
         S_BEQ:      state_nxt = fetch_or_halt;
         S_JAL:      state_nxt = S_ALUWB;
         S_HALT:     if (!halt_req) state_nxt = S_FETCH;
         S_FAULT:    state_nxt = S_FAULT;
         default:    state_nxt = S_FAULT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_FETCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      c = '0;
      case (state)
         S_FETCH: begin
            c.mem_req    = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALURESULT;
            c.ir_write   = mem.mem_ready;
            c.pc_write   = mem.mem_ready;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_REG;
            c.alu_src_b = SRCB_IMM;
            c.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            c.mem_req = 1'b1;
            c.adr_src = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.mem_req   = 1'b1;
            c.mem_write = 1'b1;
            c.adr_src   = 1'b1;
         end
         S_EXECR, S_EXECI: begin
            c.alu_src_a = SRCA_REG;
            c.alu_src_b = (state == S_EXECI) ? SRCB_IMM : SRCB_REG;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a  = SRCA_REG;
            c.alu_src_b  = SRCB_REG;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
            c.imm_src    = IMM_B;
            c.pc_write   = Zero;
         end
         S_JAL: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALUOUT;
            c.imm_src    = IMM_J;
            c.pc_write   = 1'b1;
         end
         S_HALT:  c.halted = 1'b1;
         S_FAULT: c.fault  = 1'b1;
         default: ;
      endcase
   end

   // Reset forces every output low at once, including mem_req in FETCH.
   assign ctrl = reset ? c : '0;

   assign mem.mem_req  = ctrl.mem_req;
   assign mem.MemWrite = ctrl.mem_write;
   assign AdrSrc       = ctrl.adr_src;
   assign IRWrite      = ctrl.ir_write;
   assign PCWrite      = ctrl.pc_write;
   assign RegWrite     = ctrl.reg_write;
   assign ALUSrcA      = ctrl.alu_src_a;
   assign ALUSrcB      = ctrl.alu_src_b;
   assign ResultSrc    = ctrl.result_src;
   assign ALUOp        = ctrl.alu_op;
   assign ImmSrc       = ctrl.imm_src;
   assign halted       = ctrl.halted;
   assign fault        = ctrl.fault;

endmodule

// File: tb/tb_riscv_multi_mainfsm.sv
// Directed bench for riscv_multi_mainfsm: per-cycle control-word checks against hand-written vectors.
module tb_riscv_multi_mainfsm;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic       Zero;
   logic       halt_req;
   logic       AdrSrc, IRWrite, PCWrite, RegWrite, halted, fault;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc;
   logic [17:0] outv;

   int n_checks = 0;
   int n_fail   = 0;

   riscv_multi_mainfsm_if mif ();

   riscv_multi_mainfsm #(.TIMEOUT(4), .WAIT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem       (mif),
      .op        (op),
      .Zero      (Zero),
      .halt_req  (halt_req),
      .AdrSrc    (AdrSrc),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .RegWrite  (RegWrite),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ResultSrc (ResultSrc),
      .ALUOp     (ALUOp),
      .ImmSrc    (ImmSrc),
      .halted    (halted),
      .fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, halted, fault}
   assign outv = {mif.mem_req, mif.MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, halted, fault};

   localparam logic [17:0] V_ZERO     = 18'h0;
   localparam logic [17:0] V_FETCH_W  = {6'b100000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] V_FETCH_R  = {6'b100110, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] V_DECODE   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] V_MEMADR_L = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] V_MEMADR_S = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
   localparam logic [17:0] V_MEMREAD  = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] V_MEMWB    = {6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] V_MEMWRITE = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] V_EXECR    = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
   localparam logic [17:0] V_EXECI    = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
   localparam logic [17:0] V_ALUWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
   localparam logic [17:0] V_BEQ_Z1   = {6'b000010, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
   localparam logic [17:0] V_BEQ_Z0   = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
   localparam logic [17:0] V_JAL      = {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00};
   localparam logic [17:0] V_HALT     = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
   localparam logic [17:0] V_FAULT    = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

   // One cycle of stimulus: inputs applied at the falling edge, outputs expected 1 ns later.
   typedef struct packed {
      logic        rdy;
      logic        z;
      logic        hr;
      logic [17:0] exp;
   } step_t;

   task automatic test_reset();
      reset = 1'b0; mif.mem_ready = 1'b0; Zero = 1'b0; halt_req = 1'b0; op = 7'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (outv !== V_ZERO) begin n_fail++; $display("FAIL reset_outputs: got %05h want %05h", outv, V_ZERO); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if (outv !== V_FETCH_W) begin n_fail++; $display("FAIL reset_release_req: got %05h want %05h", outv, V_FETCH_W); end
   endtask

   task automatic test_lw();
      step_t s[5];
      op = 7'b0000011;
      s = '{'{1'b1, 1'b0, 1'b0, V_FETCH_R}, '{1'b1, 1'b0, 1'b0, V_DECODE},
            '{1'b1, 1'b0, 1'b0, V_MEMADR_L}, '{1'b1, 1'b0, 1'b0, V_MEMREAD},
            '{1'b1, 1'b0, 1'b0, V_MEMWB}};
      foreach (s[i]) begin
         @(negedge clk);
         mif.mem_ready = s[i].rdy; Zero = s[i].z; halt_req = s[i].hr;
         #1;
         n_checks++;
         if (outv !== s[i].exp) begin n_fail++; $display("FAIL lw step %0d: got %05h want %05h", i, outv, s[i].exp); end
      end
   endtask

   task automatic test_sw_wait();
      step_t s[8];
      op = 7'b0100011;
      s = '{'{1'b1, 1'b0, 1'b0, V_FETCH_R}, '{1'b0, 1'b0, 1'b0, V_DECODE},
            '{1'b0, 1'b0, 1'b0, V_MEMADR_S}, '{1'b0, 1'b0, 1'b0, V_MEMWRITE},
            '{1'b0, 1'b0, 1'b0, V_MEMWRITE}, '{1'b0, 1'b0, 1'b0, V_MEMWRITE},
            '{1'b1, 1'b0, 1'b0, V_MEMWRITE}, '{1'b0, 1'b0, 1'b0, V_FETCH_W}};
      foreach (s[i]) begin
         @(negedge clk);
         mif.mem_ready = s[i].rdy; Zero = s[i].z; halt_req = s[i].hr;
         #1;
         n_checks++;
         if (outv !== s[i].exp) begin n_fail++; $display("FAIL sw_wait step %0d: got %05h want %05h", i, outv, s[i].exp); end
      end
   endtask

   task automatic test_alu();
      step_t s[8];
      s = '{'{1'b1, 1'b0, 1'b0, V_FETCH_R}, '{1'b0, 1'b0, 1'b0, V_DECODE},
            '{1'b0, 1'b0, 1'b0, V_EXECR},   '{1'b0, 1'b0, 1'b0, V_ALUWB},
            '{1'b1, 1'b0, 1'b0, V_FETCH_R}, '{1'b0, 1'b0, 1'b0, V_DECODE},
            '{1'b0, 1'b0, 1'b0, V_EXECI},   '{1'b0, 1'b0, 1'b0, V_ALUWB}};
      foreach (s[i]) begin
         @(negedge clk);
         op = (i < 4) ? 7'b0110011 : 7'b0010011;
         mif.mem_ready = s[i].rdy; Zero = s[i].z; halt_req = s[i].hr;
         #1;
         n_checks++;
         if (outv !== s[i].exp) begin n_fail++; $display("FAIL alu step %0d: got %05h want %05h", i, outv, s[i].exp); end
      end
   endtask

   task automatic test_beq();
      step_t s[6];
      op = 7'b1100011;
      s = '{'{1'b1, 1'b1, 1'b0, V_FETCH_R}, '{1'b0, 1'b1, 1'b0, V_DECODE},
            '{1'b0, 1'b1, 1'b0, V_BEQ_Z1},  '{1'b1, 1'b0, 1'b0, V_FETCH_R},
            '{1'b0, 1'b0, 1'b0, V_DECODE},  '{1'b0, 1'b0, 1'b0, V_BEQ_Z0}};
      foreach (s[i]) begin
         @(negedge clk);
         mif.mem_ready = s[i].rdy; Zero = s[i].z; halt_req = s[i].hr;
         #1;
         n_checks++;
         if (outv !== s[i].exp) begin n_fail++; $display("FAIL beq step %0d: got %05h want %05h", i, outv, s[i].exp); end
      end
   endtask

   task automatic test_jal();
      step_t s[4];
      op = 7'b1101111;
      s = '{'{1'b1, 1'b0, 1'b0, V_FETCH_R}, '{1'b0, 1'b0, 1'b0, V_DECODE},
            '{1'b0, 1'b0, 1'b0, V_JAL},     '{1'b0, 1'b0, 1'b0, V_ALUWB}};
      foreach (s[i]) begin
         @(negedge clk);
         mif.mem_ready = s[i].rdy; Zero = s[i].z; halt_req = s[i].hr;
         #1;
         n_checks++;
         if (outv !== s[i].exp) begin n_fail++; $display("FAIL jal step %0d: got %05h want %05h", i, outv, s[i].exp); end
      end
   endtask

   task automatic test_halt();
      step_t s[13];
      op = 7'b0110011;
      s = '{'{1'b1, 1'b0, 1'b0, V_FETCH_R}, '{1'b0, 1'b0, 1'b0, V_DECODE},
            '{1'b0, 1'b0, 1'b0, V_EXECR},   '{1'b0, 1'b0, 1'b1, V_ALUWB},
            '{1'b0, 1'b0, 1'b1, V_HALT},    '{1'b1, 1'b0, 1'b1, V_HALT},
            '{1'b0, 1'b0, 1'b0, V_HALT},    '{1'b0, 1'b0, 1'b0, V_FETCH_W},
            '{1'b0, 1'b0, 1'b1, V_FETCH_W}, '{1'b1, 1'b0, 1'b1, V_FETCH_R},
            '{1'b0, 1'b0, 1'b0, V_DECODE},  '{1'b0, 1'b0, 1'b0, V_EXECR},
            '{1'b0, 1'b0, 1'b0, V_ALUWB}};
      foreach (s[i]) begin
         @(negedge clk);
         mif.mem_ready = s[i].rdy; Zero = s[i].z; halt_req = s[i].hr;
         #1;
         n_checks++;
         if (outv !== s[i].exp) begin n_fail++; $display("FAIL halt step %0d: got %05h want %05h", i, outv, s[i].exp); end
      end
   endtask

   // Ready arrives on the very cycle the wait count equals TIMEOUT (4): completion must win.
   task automatic test_timeout_boundary();
      step_t s[8];
      op = 7'b0010011;
      s = '{'{1'b0, 1'b0, 1'b0, V_FETCH_W}, '{1'b0, 1'b0, 1'b0, V_FETCH_W},
            '{1'b0, 1'b0, 1'b0, V_FETCH_W}, '{1'b0, 1'b0, 1'b0, V_FETCH_W},
            '{1'b1, 1'b0, 1'b0, V_FETCH_R}, '{1'b0, 1'b0, 1'b0, V_DECODE},
            '{1'b0, 1'b0, 1'b0, V_EXECI},   '{1'b0, 1'b0, 1'b0, V_ALUWB}};
      foreach (s[i]) begin
         @(negedge clk);
         mif.mem_ready = s[i].rdy; Zero = s[i].z; halt_req = s[i].hr;
         #1;
         n_checks++;
         if (outv !== s[i].exp) begin n_fail++; $display("FAIL timeout_boundary step %0d: got %05h want %05h", i, outv, s[i].exp); end
      end
   endtask

   task automatic test_timeout_fault();
      step_t s[6];
      s = '{'{1'b0, 1'b0, 1'b0, V_FETCH_W}, '{1'b0, 1'b0, 1'b0, V_FETCH_W},
            '{1'b0, 1'b0, 1'b0, V_FETCH_W}, '{1'b0, 1'b0, 1'b0, V_FETCH_W},
            '{1'b0, 1'b0, 1'b0, V_FETCH_W}, '{1'b1, 1'b0, 1'b0, V_FAULT}};
      foreach (s[i]) begin
         @(negedge clk);
         mif.mem_ready = s[i].rdy; Zero = s[i].z; halt_req = s[i].hr;
         #1;
         n_checks++;
         if (outv !== s[i].exp) begin n_fail++; $display("FAIL timeout step %0d: got %05h want %05h", i, outv, s[i].exp); end
      end
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         mif.mem_ready = k[0]; halt_req = k[1]; Zero = k[2];
      end
      #1;
      n_checks++;
      if (outv !== V_FAULT) begin n_fail++; $display("FAIL fault_sticky: got %05h want %05h", outv, V_FAULT); end
      @(negedge clk);
      reset = 1'b0; mif.mem_ready = 1'b0; halt_req = 1'b0; Zero = 1'b0;
      #1;
      n_checks++;
      if (outv !== V_ZERO) begin n_fail++; $display("FAIL fault_reset_clear: got %05h want %05h", outv, V_ZERO); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if (outv !== V_FETCH_W) begin n_fail++; $display("FAIL fault_reset_release: got %05h want %05h", outv, V_FETCH_W); end
   endtask

   task automatic test_illegal_op();
      step_t s[6];
      op = 7'b0001111;
      s = '{'{1'b1, 1'b0, 1'b0, V_FETCH_R}, '{1'b0, 1'b0, 1'b0, V_DECODE},
            '{1'b1, 1'b0, 1'b0, V_FAULT},   '{1'b0, 1'b1, 1'b1, V_FAULT},
            '{1'b1, 1'b0, 1'b0, V_FAULT},   '{1'b0, 1'b0, 1'b0, V_FAULT}};
      foreach (s[i]) begin
         @(negedge clk);
         mif.mem_ready = s[i].rdy; Zero = s[i].z; halt_req = s[i].hr;
         #1;
         n_checks++;
         if (outv !== s[i].exp) begin n_fail++; $display("FAIL illegal_op step %0d: got %05h want %05h", i, outv, s[i].exp); end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (outv !== V_ZERO) begin n_fail++; $display("FAIL illegal_op_reset: got %05h want %05h", outv, V_ZERO); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_alu();
      test_beq();
      test_jal();
      test_halt();
      test_timeout_boundary();
      test_timeout_fault();
      test_illegal_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
